// File: rtl/aer_out_tx.sv
// AER output transmitter: queues neuron-array events in a FIFO and drives a
// 4-phase REQ/ACK handshake toward an off-core receiver with an asynchronous ACK.
`timescale 1ns/1ps
module aer_out_tx #(
    parameter int CORE_W     = 8,
    parameter int CORE_H     = 8,
    parameter int CORE_C     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  SPK_VALID,
    output logic                                                  SPK_READY,
    input  logic [1:0]                                            SPK_TYPE,
    input  logic [$clog2(CORE_C)-1:0]                             SPK_CH,
    input  logic [$clog2(CORE_W*CORE_H)-1:0]                      SPK_NEUR,
    output logic                                                  AEROUT_REQ,
    output logic [2+$clog2(CORE_C)+$clog2(CORE_W*CORE_H)-1:0]     AEROUT_ADDR,
    input  logic                                                  AEROUT_ACK,
    input  logic                                                  CNT_CLR,
    output logic [$clog2(FIFO_DEPTH):0]                           FIFO_LEVEL,
    output logic                                                  BUSY,
    output logic [15:0]                                           EVT_CNT,
    output logic                                                  ERR_RSVD
);
    localparam int AW    = 2 + $clog2(CORE_C) + $clog2(CORE_W*CORE_H);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ready_q, ready_d;
    logic              avail_q, avail_d;
    logic              ack_meta_q, ack_s_q;
    logic              req_q, req_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [SC_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [15:0]       evt_cnt_q, evt_cnt_d;
    logic              err_q, err_d;
    logic              accept, push, pop;

    assign accept = SPK_VALID && ready_q;
    assign push   = accept && (SPK_TYPE != 2'b11);

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        setup_cnt_d = setup_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // A stale ACK left over from a reset must settle low before a new transfer.
                if (avail_q && !ack_s_q) begin
                    pop         = 1'b1;
                    addr_d      = mem_q[rd_ptr_q];
                    setup_cnt_d = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SC_W'(SETUP_CYC - 1)) begin
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = WAIT_REL;
                    if (evt_cnt_q != 16'hFFFF) evt_cnt_d = evt_cnt_q + 16'd1;
                end
            end
            WAIT_REL: begin
                if (!ack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (CNT_CLR) evt_cnt_d = '0;
        err_d = CNT_CLR ? 1'b0 : (err_q || (accept && SPK_TYPE == 2'b11));

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        ready_d  = (level_d != LVL_W'(FIFO_DEPTH));
        // Availability lags the level by one cycle, so a word pushed at one edge is
        // popped no earlier than two edges later; a pop is never followed by
        // another IDLE cycle soon enough for the lag to matter.
        avail_d  = (level_q != '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            avail_q     <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            setup_cnt_q <= '0;
            evt_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            avail_q     <= avail_d;
            ack_meta_q  <= AEROUT_ACK;
            ack_s_q     <= ack_meta_q;
            req_q       <= req_d;
            addr_q      <= addr_d;
            setup_cnt_q <= setup_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and level alone decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {SPK_TYPE, SPK_CH, SPK_NEUR};
    end

    assign SPK_READY   = ready_q;
    assign AEROUT_REQ  = req_q;
    assign AEROUT_ADDR = addr_q;
    assign FIFO_LEVEL  = level_q;
    assign BUSY        = (level_q != '0) || (state_q != IDLE);
    assign EVT_CNT     = evt_cnt_q;
    assign ERR_RSVD    = err_q;
endmodule

// File: tb/tb_aer_out_tx.sv
// Directed bench for aer_out_tx: a timed 4-phase responder, an address monitor
// and hand-computed expectations for reset, single, burst, marker, reset and error cases.
`timescale 1ns/1ps
module tb_aer_out_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SPK_VALID = 1'b0;
    logic        SPK_READY;
    logic [1:0]  SPK_TYPE = 2'b00;
    logic [2:0]  SPK_CH = '0;
    logic [5:0]  SPK_NEUR = '0;
    logic        AEROUT_REQ;
    logic [10:0] AEROUT_ADDR;
    logic        AEROUT_ACK;
    logic        CNT_CLR = 1'b0;
    logic [4:0]  FIFO_LEVEL;
    logic        BUSY;
    logic [15:0] EVT_CNT;
    logic        ERR_RSVD;

    logic        auto_mode = 1'b1;
    logic        resp_ack = 1'b0;
    logic        man_ack = 1'b0;
    int          ack_dly = 50;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] cur_addr = '0;
    int          stab_err = 0;

    always #5 clk = ~clk;
    assign AEROUT_ACK = auto_mode ? resp_ack : man_ack;

    aer_out_tx dut (
        .clk(clk), .rst(rst),
        .SPK_VALID(SPK_VALID), .SPK_READY(SPK_READY), .SPK_TYPE(SPK_TYPE),
        .SPK_CH(SPK_CH), .SPK_NEUR(SPK_NEUR),
        .AEROUT_REQ(AEROUT_REQ), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_ACK(AEROUT_ACK),
        .CNT_CLR(CNT_CLR), .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY),
        .EVT_CNT(EVT_CNT), .ERR_RSVD(ERR_RSVD)
    );

    // Responder: ACK rises ack_dly ns after REQ, falls 50 ns after REQ falls.
    initial forever begin
        wait (AEROUT_REQ === 1'b1);
        #(ack_dly) resp_ack = 1'b1;
        wait (AEROUT_REQ === 1'b0);
        #50 resp_ack = 1'b0;
    end

    always @(posedge AEROUT_REQ) begin
        got_q.push_back(AEROUT_ADDR);
        cur_addr = AEROUT_ADDR;
    end

    always @(negedge clk) if (AEROUT_REQ && AEROUT_ADDR != cur_addr) stab_err++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [2:0] ch, input logic [5:0] nr);
        int n = 0;
        @(negedge clk);
        SPK_VALID = 1'b1; SPK_TYPE = t; SPK_CH = ch; SPK_NEUR = nr;
        while (!SPK_READY && n < 3000) begin @(negedge clk); n++; end
        if (!SPK_READY) check("push_timeout", 0, 1);
        else if (t != 2'b11) exp_q.push_back({t, ch, nr});
        @(posedge clk);
        #1 SPK_VALID = 1'b0;
    endtask

    task automatic wait_evt(input logic [15:0] target, input string tag);
        int n = 0;
        while (EVT_CNT !== target && n < 5000) begin @(negedge clk); n++; end
        check(tag, EVT_CNT, target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (BUSY !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check(tag, BUSY, 0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (AEROUT_REQ !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check(tag, AEROUT_REQ, 1);
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [10:0] last;

        // 1: reset
        @(negedge clk);
        check("rst_req_in", AEROUT_REQ, 0);
        check("rst_ready_in", SPK_READY, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", AEROUT_REQ, 0);
        check("rst_addr", AEROUT_ADDR, 0);
        check("rst_ready", SPK_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_evt", EVT_CNT, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_err", ERR_RSVD, 0);

        // 2: single spike CH=3 NEUR=37
        push(2'b00, 3'd3, 6'd37);
        wait_evt(16'd1, "t2_evt");
        wait_idle("t2_idle");
        check("t2_addr", AEROUT_ADDR, 11'h0E5);
        check("t2_req", AEROUT_REQ, 0);
        compare_queues("t2_order");

        // 3: burst of 20 with the first ACK held off 1 us
        ack_dly = 1000;
        fork
            begin
                for (int i = 0; i < 20; i++) push(2'b00, 3'd0, 6'(i));
            end
            begin
                wait_req("t3_req");
                #600;
                check("t3_level_full", FIFO_LEVEL, 16);
                check("t3_ready_low", SPK_READY, 0);
                check("t3_busy", BUSY, 1);
                ack_dly = 50;
            end
        join
        wait_evt(16'd21, "t3_evt");
        wait_idle("t3_idle");
        compare_queues("t3_order");

        // 4: 64 spikes then a time-step marker
        for (int i = 0; i < 64; i++) push(2'b00, 3'd1, 6'(i));
        push(2'b01, 3'd0, 6'd0);
        wait_evt(16'd86, "t4_evt");
        wait_idle("t4_idle");
        last = (got_q.size() > 64) ? got_q[64] : '0;
        check("t4_marker_type", last[10:9], 2'b01);
        compare_queues("t4_order");

        // 5: reset while REQ=1 and ACK=1
        auto_mode = 1'b0;
        man_ack = 1'b0;
        push(2'b00, 3'd2, 6'd10);
        push(2'b00, 3'd2, 6'd11);
        wait_req("t5_req");
        @(negedge clk);
        man_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("t5_req_drop", AEROUT_REQ, 0);
        check("t5_level_clr", FIFO_LEVEL, 0);
        check("t5_busy_clr", BUSY, 0);
        check("t5_evt_clr", EVT_CNT, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        push(2'b00, 3'd5, 6'd42);
        repeat (10) @(negedge clk);
        check("t5_stale_ack_req", AEROUT_REQ, 0);
        check("t5_stale_ack_level", FIFO_LEVEL, 1);
        check("t5_stale_ack_busy", BUSY, 1);
        man_ack = 1'b0;
        auto_mode = 1'b1;
        wait_evt(16'd1, "t5_evt");
        wait_idle("t5_idle");
        check("t5_addr", AEROUT_ADDR, 11'h16A);
        compare_queues("t5_order");

        // 6: reserved type, then counter clear
        push(2'b11, 3'd0, 6'd0);
        repeat (10) @(negedge clk);
        check("t6_req", AEROUT_REQ, 0);
        check("t6_err", ERR_RSVD, 1);
        check("t6_level", FIFO_LEVEL, 0);
        check("t6_busy", BUSY, 0);
        check("t6_no_handshake", got_q.size(), 0);
        check("t6_evt_before", EVT_CNT, 1);
        CNT_CLR = 1'b1;
        @(negedge clk);
        CNT_CLR = 1'b0;
        check("t6_err_clr", ERR_RSVD, 0);
        check("t6_evt_clr", EVT_CNT, 0);

        check("addr_stable", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
